// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard sequencer: FSM states, PC source codes
// and the hazard-detection helper.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERR      = 2'd2
    } state_e;

    localparam logic [1:0] PCSEL_SEQ = 2'b00;
    localparam logic [1:0] PCSEL_BR  = 2'b01;
    localparam logic [1:0] PCSEL_JMP = 2'b10;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // r0 is hardwired, so a load targeting it can never feed a dependent instruction.
    function automatic logic load_use_hazard(input logic       mem_read,
                                             input logic [4:0] ex_rt,
                                             input logic [4:0] rs,
                                             input logic [4:0] rt,
                                             input logic       uses_rt);
        return mem_read && (ex_rt != REG_ZERO) &&
               ((ex_rt == rs) || (uses_rt && (ex_rt == rt)));
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Handshake/control bundle between the pipeline datapath and pipe_hazard_ctrl.
// Optional perf counter outputs appear when PIPE_HAZARD_PERF_EN is defined.
interface pipe_hazard_ctrl_if #(parameter int unsigned CNT_W = 16);

    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rt;
    logic        ex_mem_read;
    logic [4:0]  ex_rt;
    logic        mem_access;
    logic        mem_branch_taken;
    logic        mem_jump;
    logic        dmem_ack;

    logic        dmem_req;
    logic        pc_we;
    logic        if_id_we;
    logic        if_id_flush;
    logic        id_ex_we;
    logic        id_ex_flush;
    logic        ex_mem_we;
    logic        ex_mem_flush;
    logic        mem_wb_flush;
    logic [1:0]  pc_sel;
    logic        mem_err;
`ifdef PIPE_HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] lu_cnt;
    logic [CNT_W-1:0] flush_cnt;
`endif

    modport master (
        output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, mem_access,
               mem_branch_taken, mem_jump, dmem_ack,
        input  dmem_req, pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush,
               ex_mem_we, ex_mem_flush, mem_wb_flush, pc_sel, mem_err
`ifdef PIPE_HAZARD_PERF_EN
        , input stall_cnt, lu_cnt, flush_cnt
`endif
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, mem_access,
               mem_branch_taken, mem_jump, dmem_ack,
        output dmem_req, pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush,
               ex_mem_we, ex_mem_flush, mem_wb_flush, pc_sel, mem_err
`ifdef PIPE_HAZARD_PERF_EN
        , output stall_cnt, lu_cnt, flush_cnt
`endif
    );

endinterface

// File: rtl/pipe_hazard_ctrl_mem_wait_timer.sv
// Data-memory wait counter: loads 1 on the first stalled cycle, counts (saturating)
// while waiting, and flags the timeout cycle. MEM_TIMEOUT of 0 never times out.
module mem_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    input  logic waiting_i,
    input  logic ack_i,
    output logic timeout_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = '0;
        if (start_i) begin
            cnt_d = CNT_W'(1);
        end else if (waiting_i && !ack_i) begin
            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign timeout_o = waiting_i && !ack_i && (MEM_TIMEOUT != 0) &&
                       (cnt_q == CNT_W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard sequencer: per-stage write-enable/flush strobes and PC select.
// Define PIPE_HAZARD_PERF_EN to add stall/load-use/redirect perf counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                clk,
    input  logic                rst,
    pipe_hazard_ctrl_if.slave   bus
);

    state_e state_q, state_d;
    logic   waiting, timeout, stall_start, lu_fire, redirect_fire, hazard;

    assign waiting = (state_q == ST_MEM_WAIT);
    assign hazard  = load_use_hazard(bus.ex_mem_read, bus.ex_rt, bus.id_rs,
                                     bus.id_rt, bus.id_uses_rt);

    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .start_i   (stall_start),
        .waiting_i (waiting),
        .ack_i     (bus.dmem_ack),
        .timeout_o (timeout)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_RUN;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d          = state_q;
        stall_start      = 1'b0;
        lu_fire          = 1'b0;
        redirect_fire    = 1'b0;
        bus.dmem_req     = 1'b0;
        bus.pc_we        = 1'b1;
        bus.if_id_we     = 1'b1;
        bus.if_id_flush  = 1'b0;
        bus.id_ex_we     = 1'b1;
        bus.id_ex_flush  = 1'b0;
        bus.ex_mem_we    = 1'b1;
        bus.ex_mem_flush = 1'b0;
        bus.mem_wb_flush = 1'b0;
        bus.pc_sel       = PCSEL_SEQ;

        unique case (state_q)
            ST_RUN, ST_MEM_WAIT: begin
                bus.dmem_req = waiting || bus.mem_access;
                if (bus.dmem_req && !bus.dmem_ack) begin
                    bus.pc_we        = 1'b0;
                    bus.if_id_we     = 1'b0;
                    bus.id_ex_we     = 1'b0;
                    bus.ex_mem_we    = 1'b0;
                    bus.mem_wb_flush = 1'b1;
                    if (!waiting)    begin state_d = ST_MEM_WAIT; stall_start = 1'b1; end
                    else if (timeout) state_d = ST_ERR;
                end else begin
                    // An acked wait cycle is a normal RUN cycle for redirect/load-use.
                    state_d = ST_RUN;
                    if (bus.mem_jump || bus.mem_branch_taken) begin
                        redirect_fire    = 1'b1;
                        bus.pc_sel       = bus.mem_jump ? PCSEL_JMP : PCSEL_BR;
                        bus.if_id_we     = 1'b0;
                        bus.if_id_flush  = 1'b1;
                        bus.id_ex_we     = 1'b0;
                        bus.id_ex_flush  = 1'b1;
                        bus.ex_mem_we    = 1'b0;
                        bus.ex_mem_flush = 1'b1;
                    end else if (hazard) begin
                        lu_fire          = 1'b1;
                        bus.pc_we        = 1'b0;
                        bus.if_id_we     = 1'b0;
                        bus.id_ex_we     = 1'b0;
                        bus.id_ex_flush  = 1'b1;
                    end
                end
            end
            default: begin
                state_d          = ST_ERR;
                bus.pc_we        = 1'b0;
                bus.if_id_we     = 1'b0;
                bus.id_ex_we     = 1'b0;
                bus.ex_mem_we    = 1'b0;
                bus.mem_wb_flush = 1'b1;
            end
        endcase

        if (!rst) begin
            stall_start      = 1'b0;
            lu_fire          = 1'b0;
            redirect_fire    = 1'b0;
            bus.dmem_req     = 1'b0;
            bus.pc_we        = 1'b0;
            bus.if_id_we     = 1'b0;
            bus.if_id_flush  = 1'b1;
            bus.id_ex_we     = 1'b0;
            bus.id_ex_flush  = 1'b1;
            bus.ex_mem_we    = 1'b0;
            bus.ex_mem_flush = 1'b1;
            bus.mem_wb_flush = 1'b1;
            bus.pc_sel       = PCSEL_SEQ;
        end
    end

    assign bus.mem_err = (state_q == ST_ERR);

`ifdef PIPE_HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, lu_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            lu_cnt_q    <= '0;
            flush_cnt_q <= '0;
        end else begin
            if ((state_q != ST_RUN) && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (lu_fire && (lu_cnt_q != '1))                lu_cnt_q    <= lu_cnt_q + CNT_W'(1);
            if (redirect_fire && (flush_cnt_q != '1))       flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
    assign bus.lu_cnt    = lu_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;
`else
    logic unused_perf;
    assign unused_perf = lu_fire ^ redirect_fire;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (MEM_TIMEOUT=4).
// Perf counter checks are compiled in when PIPE_HAZARD_PERF_EN is defined.
module tb_pipe_hazard_ctrl;

    // Output vector: {req, pc_we, ifid_we, ifid_fl, idex_we, idex_fl,
    //                 exmem_we, exmem_fl, memwb_fl, pc_sel[1:0], mem_err}
    localparam logic [11:0] EXP_RUN   = 12'b0110_1010_0000;
    localparam logic [11:0] EXP_RUNM  = 12'b1110_1010_0000;
    localparam logic [11:0] EXP_RST   = 12'b0001_0101_1000;
    localparam logic [11:0] EXP_LU    = 12'b0000_0110_0000;
    localparam logic [11:0] EXP_BR    = 12'b0101_0101_0010;
    localparam logic [11:0] EXP_BRM   = 12'b1101_0101_0010;
    localparam logic [11:0] EXP_JMP   = 12'b0101_0101_0100;
    localparam logic [11:0] EXP_STALL = 12'b1000_0000_1000;
    localparam logic [11:0] EXP_ERR   = 12'b0000_0000_1001;

    typedef struct packed {
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        urt;
        logic        mr;
        logic [4:0]  ert;
        logic        ma;
        logic        br;
        logic        jp;
        logic        ack;
        logic [11:0] exp;
    } step_t;

    logic clk = 1'b0;
    logic rst;
    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.CNT_W(16)) bus ();

    pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [11:0] outs();
        return {bus.dmem_req, bus.pc_we, bus.if_id_we, bus.if_id_flush,
                bus.id_ex_we, bus.id_ex_flush, bus.ex_mem_we, bus.ex_mem_flush,
                bus.mem_wb_flush, bus.pc_sel, bus.mem_err};
    endfunction

    task automatic drive(input step_t s);
        bus.id_rs            = s.rs;
        bus.id_rt            = s.rt;
        bus.id_uses_rt       = s.urt;
        bus.ex_mem_read      = s.mr;
        bus.ex_rt            = s.ert;
        bus.mem_access       = s.ma;
        bus.mem_branch_taken = s.br;
        bus.mem_jump         = s.jp;
        bus.dmem_ack         = s.ack;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [11:0] got;
        rst = 1'b0;
        drive('0);
        #2;
        got = outs();
        total++;
        if (got !== EXP_RST) begin bad++; $display("FAIL reset_pre_edge: got=%b want=%b", got, EXP_RST); end
        tick();
        got = outs();
        total++;
        if (got !== EXP_RST) begin bad++; $display("FAIL reset_held: got=%b want=%b", got, EXP_RST); end
        rst = 1'b1;
        @(negedge clk);
        got = outs();
        total++;
        if (got !== EXP_RUN) begin bad++; $display("FAIL reset_release: got=%b want=%b", got, EXP_RUN); end
        tick();
    endtask

    task automatic test_load_use();
        step_t tbl [7] = '{
            '{5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, EXP_LU},
            '{5'd5, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, EXP_RUN},
            '{5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, EXP_LU},
            '{5'd3, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, EXP_RUN},
            '{5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, EXP_RUN},
            '{5'd4, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, EXP_RUN},
            '{5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, EXP_RUN}
        };
        logic [11:0] got;
        for (int i = 0; i < 7; i++) begin
            drive(tbl[i]);
            @(negedge clk);
            got = outs();
            total++;
            if (got !== tbl[i].exp) begin bad++; $display("FAIL load_use[%0d]: got=%b want=%b", i, got, tbl[i].exp); end
            tick();
        end
    endtask

    task automatic test_redirect();
        step_t tbl [6] = '{
            '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, EXP_BR},
            '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, EXP_RUN},
            '{5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, EXP_JMP},
            '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, EXP_RUN},
            '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, EXP_JMP},
            '{5'd9, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0, EXP_BR}
        };
        logic [11:0] got;
        for (int i = 0; i < 6; i++) begin
            drive(tbl[i]);
            @(negedge clk);
            got = outs();
            total++;
            if (got !== tbl[i].exp) begin bad++; $display("FAIL redirect[%0d]: got=%b want=%b", i, got, tbl[i].exp); end
            tick();
        end
    endtask

    task automatic test_mem_wait();
        step_t tbl [10] = '{
            '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, EXP_STALL},
            '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, EXP_STALL},
            '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, EXP_STALL},
            '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, EXP_RUNM},
            '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, EXP_RUN},
            '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, EXP_RUNM},
            '{5'd6, 5'd0, 1'b0, 1'b1, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, EXP_STALL},
            '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, EXP_BRM},
            '{5'd6, 5'd0, 1'b0, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0, EXP_LU},
            '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, EXP_RUN}
        };
        logic [11:0] got;
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i]);
            @(negedge clk);
            got = outs();
            total++;
            if (got !== tbl[i].exp) begin bad++; $display("FAIL mem_wait[%0d]: got=%b want=%b", i, got, tbl[i].exp); end
            tick();
        end
    endtask

    task automatic test_perf();
`ifdef PIPE_HAZARD_PERF_EN
        // Since reset: 4 cycles in MEM_WAIT, 3 load-use bubbles, 5 redirects.
        @(negedge clk);
        total++;
        if (bus.stall_cnt !== 16'd4) begin bad++; $display("FAIL stall_cnt: got=%0d want=4", bus.stall_cnt); end
        total++;
        if (bus.lu_cnt !== 16'd3) begin bad++; $display("FAIL lu_cnt: got=%0d want=3", bus.lu_cnt); end
        total++;
        if (bus.flush_cnt !== 16'd5) begin bad++; $display("FAIL flush_cnt: got=%0d want=5", bus.flush_cnt); end
        tick();
`endif
    endtask

    task automatic test_timeout();
        step_t tbl [7] = '{
            '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, EXP_STALL},
            '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, EXP_STALL},
            '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, EXP_STALL},
            '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, EXP_STALL},
            '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, EXP_ERR},
            '{5'd2, 5'd0, 1'b0, 1'b1, 5'd2, 1'b0, 1'b1, 1'b0, 1'b1, EXP_ERR},
            '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, EXP_ERR}
        };
        logic [11:0] got;
        for (int i = 0; i < 7; i++) begin
            drive(tbl[i]);
            @(negedge clk);
            got = outs();
            total++;
            if (got !== tbl[i].exp) begin bad++; $display("FAIL timeout[%0d]: got=%b want=%b", i, got, tbl[i].exp); end
            tick();
        end
    endtask

    task automatic test_reset_mid_wait();
        step_t wait_s = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, EXP_STALL};
        logic [11:0] got;
        // Leave ERR via an async pulse placed away from any clock edge.
        rst = 1'b0;
        #1;
        got = outs();
        total++;
        if (got !== EXP_RST) begin bad++; $display("FAIL err_clear_rst: got=%b want=%b", got, EXP_RST); end
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(wait_s);
            @(negedge clk);
            got = outs();
            total++;
            if (got !== EXP_STALL) begin bad++; $display("FAIL mid_wait_stall[%0d]: got=%b want=%b", i, got, EXP_STALL); end
            if (i == 0) tick();
        end
        #2;
        rst = 1'b0;
        #1;
        got = outs();
        total++;
        if (got !== EXP_RST) begin bad++; $display("FAIL mid_wait_rst: got=%b want=%b", got, EXP_RST); end
        drive('0);
        #1;
        rst = 1'b1;
        @(negedge clk);
        got = outs();
        total++;
        if (got !== EXP_RUN) begin bad++; $display("FAIL mid_wait_release: got=%b want=%b", got, EXP_RUN); end
        tick();
        wait_s.ack = 1'b1;
        drive(wait_s);
        @(negedge clk);
        got = outs();
        total++;
        if (got !== EXP_RUNM) begin bad++; $display("FAIL post_reset_access: got=%b want=%b", got, EXP_RUNM); end
        tick();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_redirect();
        test_mem_wait();
        test_perf();
        test_timeout();
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
